// File: rtl/deser_link_pkg.sv
// Shared types and constants for the deserializer link controller.
//   link_state_e      : link controller FSM state encoding
//   COMMA             : alignment comma byte (K28.5 decoded)
//   DESER_RST_CYCLES  : cycles deser_rst_o is held after reset release
//   CNT_W             : width of the statistics counters
package deser_link_pkg;

  typedef enum logic [2:0] {
    ST_RESET    = 3'd0,
    ST_HUNT     = 3'd1,
    ST_SLIPWAIT = 3'd2,
    ST_ACQ      = 3'd3,
    ST_LOCKED   = 3'd4
  } link_state_e;

  localparam logic [7:0]  COMMA            = 8'hBC;
  localparam int unsigned DESER_RST_CYCLES = 4;
  localparam int unsigned CNT_W            = 16;

endpackage

// File: rtl/deser_err_window.sv
// Sliding-window error monitor used while the link is locked.
// Counts words in fixed windows of ErrWindow words and errored words
// within the current window; flags the word that reaches ErrThreshold.
//   clk_i, rst_ni : clock, async active-low reset
//   word_i        : word strobe
//   err_i         : current word is errored
//   en_i          : window counting enabled (link locked)
//   clr_i         : synchronous clear of both window counters
//   hit_c_o       : combinational; this word reaches the error threshold
module deser_err_window #(
  parameter int unsigned ErrThreshold = 4,
  parameter int unsigned ErrWindow    = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic word_i,
  input  logic err_i,
  input  logic en_i,
  input  logic clr_i,
  output logic hit_c_o
);

  localparam int unsigned WIN_W = (ErrWindow > 1) ? $clog2(ErrWindow) : 1;
  localparam int unsigned ERR_W = $clog2(ErrThreshold + 1);

  logic [WIN_W-1:0] word_cnt_q, word_cnt_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             wrap;

  assign wrap = (word_cnt_q == WIN_W'(ErrWindow - 1));

  // Threshold is evaluated before the wrap clear, so a hit on the wrap word wins.
  assign hit_c_o = en_i & word_i & err_i & (err_cnt_q == ERR_W'(ErrThreshold - 1));

  // Next-state for window position and in-window error count.
  always_comb begin
    word_cnt_d = word_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (clr_i) begin
      word_cnt_d = '0;
      err_cnt_d  = '0;
    end else if (en_i && word_i) begin
      word_cnt_d = wrap ? '0 : word_cnt_q + WIN_W'(1);
      if (hit_c_o || wrap) begin
        err_cnt_d = '0;
      end else if (err_i) begin
        err_cnt_d = err_cnt_q + ERR_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      word_cnt_q <= word_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

endmodule

// File: rtl/deser_link_ctrl.sv
// Deserializer link controller: holds the deserializer in reset, hunts for
// comma alignment (requesting bit slips on timeout), acquires lock after
// consecutive clean commas, forwards payload while locked and drops lock
// when too many errored words fall inside one window.
// Optional statistics counters are built when DESER_LINK_STATS_EN is defined;
// otherwise err_cnt_o/loss_cnt_o are tied to zero.
//   clk_i, rst_ni          : clock, async active-low reset
//   data_i, eob_i          : decoded byte and its word strobe
//   code_err_i, disp_err_i : per-word code / disparity error flags
//   clear_i                : clears statistics counters
//   deser_rst_o            : active-high deserializer reset
//   slip_o                 : one-cycle bit-slip request
//   lock_o                 : link locked
//   data_o, valid_o        : forwarded payload byte and its strobe
//   err_cnt_o, loss_cnt_o  : saturating errored-word / lock-loss counts
module deser_link_ctrl
  import deser_link_pkg::*;
#(
  parameter int unsigned AcqCount     = 4,
  parameter int unsigned ErrThreshold = 4,
  parameter int unsigned ErrWindow    = 16,
  parameter int unsigned HuntTimeout  = 20,
  parameter int unsigned SlipWait     = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [7:0]       data_i,
  input  logic             eob_i,
  input  logic             code_err_i,
  input  logic             disp_err_i,
  input  logic             clear_i,
  output logic             deser_rst_o,
  output logic             slip_o,
  output logic             lock_o,
  output logic [7:0]       data_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [CNT_W-1:0] loss_cnt_o
);

  localparam int unsigned RST_W  = $clog2(DESER_RST_CYCLES);
  localparam int unsigned HUNT_W = $clog2(HuntTimeout + 1);
  localparam int unsigned SLIP_W = $clog2(SlipWait + 1);
  localparam int unsigned ACQ_W  = $clog2(AcqCount + 1);

  link_state_e       state_q, state_d;
  logic [RST_W-1:0]  rst_cnt_q, rst_cnt_d;
  logic [HUNT_W-1:0] hunt_cnt_q, hunt_cnt_d;
  logic [SLIP_W-1:0] slip_cnt_q, slip_cnt_d;
  logic [ACQ_W-1:0]  acq_cnt_q, acq_cnt_d;
  logic              slip_q, slip_d;
  logic              valid_q, valid_d;
  logic [7:0]        data_q, data_d;

  logic is_err, is_comma, locked, win_hit;

  assign is_err   = code_err_i | disp_err_i;
  assign is_comma = (data_i == COMMA) & ~is_err;
  assign locked   = (state_q == ST_LOCKED);

  deser_err_window #(
    .ErrThreshold (ErrThreshold),
    .ErrWindow    (ErrWindow)
  ) u_err_window (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .word_i  (eob_i),
    .err_i   (is_err),
    .en_i    (locked),
    .clr_i   (~locked),
    .hit_c_o (win_hit)
  );

  // Link FSM next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    rst_cnt_d  = rst_cnt_q;
    hunt_cnt_d = hunt_cnt_q;
    slip_cnt_d = slip_cnt_q;
    acq_cnt_d  = acq_cnt_q;
    slip_d     = 1'b0;
    valid_d    = 1'b0;
    data_d     = data_q;

    unique case (state_q)
      ST_RESET: begin
        if (rst_cnt_q == RST_W'(DESER_RST_CYCLES - 1)) begin
          state_d    = ST_HUNT;
          rst_cnt_d  = '0;
          hunt_cnt_d = '0;
        end else begin
          rst_cnt_d = rst_cnt_q + RST_W'(1);
        end
      end

      ST_HUNT: begin
        if (eob_i) begin
          if (is_comma) begin
            hunt_cnt_d = '0;
            acq_cnt_d  = ACQ_W'(1);
            state_d    = (AcqCount <= 1) ? ST_LOCKED : ST_ACQ;
          end else if (hunt_cnt_q == HUNT_W'(HuntTimeout - 1)) begin
            slip_d     = 1'b1;
            hunt_cnt_d = '0;
            slip_cnt_d = '0;
            state_d    = ST_SLIPWAIT;
          end else begin
            hunt_cnt_d = hunt_cnt_q + HUNT_W'(1);
          end
        end
      end

      // Words are discarded while the deserializer settles after a slip.
      ST_SLIPWAIT: begin
        if (eob_i) begin
          if (slip_cnt_q == SLIP_W'(SlipWait - 1)) begin
            slip_cnt_d = '0;
            hunt_cnt_d = '0;
            state_d    = ST_HUNT;
          end else begin
            slip_cnt_d = slip_cnt_q + SLIP_W'(1);
          end
        end
      end

      ST_ACQ: begin
        if (eob_i) begin
          if (is_err) begin
            hunt_cnt_d = '0;
            state_d    = ST_HUNT;
          end else if (is_comma) begin
            if (acq_cnt_q == ACQ_W'(AcqCount - 1)) begin
              state_d = ST_LOCKED;
            end else begin
              acq_cnt_d = acq_cnt_q + ACQ_W'(1);
            end
          end
        end
      end

      ST_LOCKED: begin
        if (eob_i) begin
          if (win_hit) begin
            hunt_cnt_d = '0;
            state_d    = ST_HUNT;
          end else if (!is_err && !is_comma) begin
            valid_d = 1'b1;
            data_d  = data_i;
          end
        end
      end

      default: begin
        state_d = ST_RESET;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_RESET;
      rst_cnt_q  <= '0;
      hunt_cnt_q <= '0;
      slip_cnt_q <= '0;
      acq_cnt_q  <= '0;
      slip_q     <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= 8'h00;
    end else begin
      state_q    <= state_d;
      rst_cnt_q  <= rst_cnt_d;
      hunt_cnt_q <= hunt_cnt_d;
      slip_cnt_q <= slip_cnt_d;
      acq_cnt_q  <= acq_cnt_d;
      slip_q     <= slip_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
    end
  end

  assign deser_rst_o = (state_q == ST_RESET);
  assign lock_o      = locked;
  assign slip_o      = slip_q;
  assign valid_o     = valid_q;
  assign data_o      = data_q;

`ifdef DESER_LINK_STATS_EN
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] loss_cnt_q, loss_cnt_d;

  // Saturating statistics; clear_i overrides a coincident increment.
  always_comb begin
    err_cnt_d  = err_cnt_q;
    loss_cnt_d = loss_cnt_q;
    if (clear_i) begin
      err_cnt_d  = '0;
      loss_cnt_d = '0;
    end else begin
      if (eob_i && is_err && (state_q != ST_RESET) && (err_cnt_q != '1)) begin
        err_cnt_d = err_cnt_q + CNT_W'(1);
      end
      if (win_hit && (loss_cnt_q != '1)) begin
        loss_cnt_d = loss_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_cnt_q  <= '0;
      loss_cnt_q <= '0;
    end else begin
      err_cnt_q  <= err_cnt_d;
      loss_cnt_q <= loss_cnt_d;
    end
  end

  assign err_cnt_o  = err_cnt_q;
  assign loss_cnt_o = loss_cnt_q;
`else
  logic unused_clear;
  assign unused_clear = clear_i;
  assign err_cnt_o    = '0;
  assign loss_cnt_o   = '0;
`endif

endmodule

// File: doc/deser_link_ctrl.md
DESER_LINK_CTRL -- requirements
Module: deser_link_ctrl

Interface
REQ-001 Parameters SHALL be:
- AcqCount, default 4: consecutive clean commas needed to lock.
- ErrThreshold, default 4: errored words within one window that force loss of lock.
- ErrWindow, default 16: window length in words, power of two.
- HuntTimeout, default 20: words without a comma before a slip.
- SlipWait, default 8: words ignored after a slip.

REQ-002 Ports SHALL be, clock and reset first:
- clk_i  in  1  single clock.
- rst_ni  in  1  asynchronous active-low reset.
- data_i  in  8  decoded byte from deserializer.
- eob_i  in  1  strobe; data_i and error flags valid this cycle.
- code_err_i  in  1  code violation on current word.
- disp_err_i  in  1  disparity error on current word.
- clear_i  in  1  clears statistics counters.
- deser_rst_o  out  1  active-high reset to deserializer.
- slip_o  out  1  one-cycle bit-slip request.
- lock_o  out  1  link locked.
- data_o  out  8  forwarded payload byte.
- valid_o  out  1  data_o valid.
- err_cnt_o  out  16  saturating errored-word count.
- loss_cnt_o  out  16  saturating lock-loss count.

REQ-003 There SHALL be exactly one clock, clk_i; reset SHALL be rst_ni, asynchronous assert, active-low.

Function
REQ-004 A "word" SHALL be any cycle with eob_i=1; all word counters SHALL advance only on such cycles.
REQ-005 A word SHALL be "errored" when code_err_i or disp_err_i is 1, and a "comma" when data_i==8'hBC and it is not errored.
REQ-006 The FSM SHALL have the states RESET, HUNT, SLIPWAIT, ACQ and LOCKED.
REQ-007 In RESET, deser_rst_o=1 for 4 cycles, then the FSM SHALL go to HUNT.
REQ-008 In HUNT:
- A comma SHALL go to ACQ with acquisition count 1.
- HuntTimeout consecutive non-comma words SHALL pulse slip_o for one cycle and go to SLIPWAIT.
REQ-009 SLIPWAIT SHALL discard SlipWait words, then return to HUNT with the timeout cleared.
REQ-010 In ACQ:
- Each comma SHALL increment the acquisition count; reaching AcqCount SHALL go to LOCKED.
- Any errored word SHALL return to HUNT.
- Non-comma clean words SHALL be ignored.
REQ-011 lock_o SHALL be a decode of the state register (1 only in LOCKED).
REQ-012 In LOCKED:
- Each clean non-comma word SHALL appear on data_o with valid_o=1 exactly one cycle after its eob_i.
- Commas and errored words SHALL NOT be forwarded.
- valid_o SHALL be 0 in all other states and cycles.
REQ-013 Error window in LOCKED:
- A word counter SHALL wrap every ErrWindow words, clearing the window error count on wrap.
- Reaching ErrThreshold within a window SHALL go to HUNT and increment loss_cnt_o.
- If the threshold error and the wrap fall on the same word, the threshold check SHALL win.
REQ-014 err_cnt_o SHALL increment on every errored word in any state except RESET.
REQ-015 Both counters SHALL saturate at 16'hFFFF.
REQ-016 If clear_i coincides with an increment, the counter SHALL become 0.

Reset
REQ-017 While rst_ni=0:
- The state SHALL be RESET and deser_rst_o=1.
- slip_o, lock_o, valid_o SHALL be 0, data_o 8'h00, and both counters 0.
REQ-018 Reset asserted mid-operation SHALL immediately abort any state, and a pending slip_o SHALL drop.

Configuration
REQ-019 With DESER_LINK_STATS_EN defined, err_cnt_o and loss_cnt_o SHALL behave per REQ-014..016.
REQ-020 Without DESER_LINK_STATS_EN, both counters SHALL be tied to 0 and no counter flops inferred; the port list is unchanged.

Structure
REQ-021 Package deser_link_pkg SHALL hold:
- the state enum;
- the COMMA constant 8'hBC;
- the deserializer reset hold length of 4;
- the counter width 16.
REQ-022 The window/threshold logic SHALL be sub-module deser_err_window, with inputs word strobe, error, enable and clear, and a threshold-hit output.

Verification
REQ-023 Reset release with clean commas every 4th word -> deser_rst_o high 4 cycles, then lock_o=1 after the 4th comma.
REQ-024 Only 8'h00 words -> slip_o pulses after word 20, then every 28 words; lock_o stays 0.
REQ-025 Locked, payload 8'h11,8'h22 -> data_o=8'h11 then 8'h22, each valid_o one cycle after its eob_i; commas produce no valid_o.
REQ-026 Locked, 4 code_err_i words within 16 words -> HUNT; lock_o=0, loss_cnt_o=1, err_cnt_o=4.
REQ-027 Locked, 3 errors, window wrap, 3 more errors -> stays locked.
REQ-028 clear_i together with an errored word -> err_cnt_o=0; 70000 errored words -> err_cnt_o=16'hFFFF.
